// File: rtl/fpu_norm_pipe.sv
// Two-stage normalise/round/pack pipeline producing IEEE-754 single-precision results.
// Stage 1 aligns the leading one to the hidden-bit position; stage 2 rounds, range-checks and packs.
module fpu_norm_pipe #(
  parameter int C_OP             = 32,
  parameter int C_EXP_PRENORM    = 10,
  parameter int C_MANT_PRENORM_W = 48,
  parameter int C_BIAS           = 127
) (
  input  logic                            Clk_CI,
  input  logic                            Rst_RBI,
  input  logic                            Valid_SI,
  output logic                            Ready_SO,
  input  logic                            Sign_prenorm_DI,
  input  logic signed [C_EXP_PRENORM-1:0] Exp_prenorm_DI,
  input  logic [C_MANT_PRENORM_W-1:0]     Mant_prenorm_DI,
  input  logic [1:0]                      Rm_SI,
  output logic                            Valid_SO,
  input  logic                            Ready_SI,
  output logic [C_OP-1:0]                 Result_DO,
  output logic                            OF_SO,
  output logic                            UF_SO,
  output logic                            NX_SO
);
  localparam int MW = C_MANT_PRENORM_W;
  localparam int PW = $clog2(MW);
  localparam int EW = C_EXP_PRENORM + 1;
  localparam int FW = 23;
  localparam int XW = C_OP - 1 - FW;
  localparam int GB = MW - 3 - FW;
  localparam logic signed [EW-1:0] NORM_POS = EW'(MW - 2);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 * C_BIAS + 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;

  logic                 s1_en, s2_en;
  logic [PW-1:0]        lead;
  logic [PW-1:0]        shamt;
  logic [MW-2:0]        norm;
  logic                 shifted_out;
  logic signed [EW-1:0] exp_norm;

  logic                 s1_valid, s1_sign, s1_zero, s1_guard, s1_sticky;
  logic [1:0]           s1_rm;
  logic signed [EW-1:0] s1_exp;
  logic [FW-1:0]        s1_frac;

  logic                 inexact, round_up, carry, to_inf;
  logic [FW-1:0]        frac_rnd;
  logic signed [EW-1:0] exp_post;
  logic [C_OP-1:0]      res;
  logic                 of, uf, nx;

  assign s2_en    = ~Valid_SO | Ready_SI;
  assign s1_en    = ~s1_valid | s2_en;
  assign Ready_SO = s1_en;

  always_comb begin
    lead = '0;
    for (int i = 0; i < MW; i++) begin
      if (Mant_prenorm_DI[i]) lead = PW'(i);
    end
  end

  // A one in the overflow position needs a right shift; its dropped LSB joins the sticky bit.
  always_comb begin
    shamt       = PW'(MW - 2) - lead;
    norm        = Mant_prenorm_DI[MW-2:0] << shamt;
    shifted_out = 1'b0;
    if (Mant_prenorm_DI[MW-1]) begin
      norm        = Mant_prenorm_DI[MW-1:1];
      shifted_out = Mant_prenorm_DI[0];
    end
    exp_norm = $signed({Exp_prenorm_DI[C_EXP_PRENORM-1], Exp_prenorm_DI})
             + $signed({{(EW-PW){1'b0}}, lead}) - NORM_POS;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_rm     <= '0;
      s1_exp    <= '0;
      s1_frac   <= '0;
    end else if (s1_en) begin
      s1_valid <= Valid_SI;
      if (Valid_SI) begin
        s1_sign   <= Sign_prenorm_DI;
        s1_zero   <= ~norm[MW-2];
        s1_guard  <= norm[GB];
        s1_sticky <= (|norm[GB-1:0]) | shifted_out;
        s1_rm     <= Rm_SI;
        s1_exp    <= exp_norm;
        s1_frac   <= norm[MW-3 -: FW];
      end
    end
  end

  always_comb begin
    inexact = s1_guard | s1_sticky;
    case (s1_rm)
      RM_RNE:  round_up = s1_guard & (s1_sticky | s1_frac[0]);
      RM_RTZ:  round_up = 1'b0;
      RM_RUP:  round_up = inexact & ~s1_sign;
      default: round_up = inexact & s1_sign;
    endcase
    {carry, frac_rnd} = {1'b0, s1_frac} + {{FW{1'b0}}, round_up};
    exp_post = s1_exp + $signed({{(EW-1){1'b0}}, carry});
    to_inf   = (s1_rm == RM_RNE) | ((s1_rm == RM_RUP) & ~s1_sign) |
               ((s1_rm == 2'd3) & s1_sign);
    res = {s1_sign, {(C_OP-1){1'b0}}};
    of  = 1'b0;
    uf  = 1'b0;
    nx  = 1'b0;
    if (!s1_zero) begin
      if (s1_exp <= EXP_ZERO) begin
        uf = 1'b1;
        nx = 1'b1;
      end else if (exp_post >= EXP_MAX) begin
        of  = 1'b1;
        nx  = 1'b1;
        res = to_inf ? {s1_sign, {XW{1'b1}}, {FW{1'b0}}}
                     : {s1_sign, {(XW-1){1'b1}}, 1'b0, {FW{1'b1}}};
      end else begin
        res = {s1_sign, exp_post[XW-1:0], frac_rnd};
        nx  = inexact;
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      Valid_SO  <= 1'b0;
      Result_DO <= '0;
      OF_SO     <= 1'b0;
      UF_SO     <= 1'b0;
      NX_SO     <= 1'b0;
    end else if (s2_en) begin
      Valid_SO <= s1_valid;
      if (s1_valid) begin
        Result_DO <= res;
        OF_SO     <= of;
        UF_SO     <= uf;
        NX_SO     <= nx;
      end
    end
  end
endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Bench for fpu_norm_pipe: directed vectors, stall and reset scenarios, then random traffic
// compared against an arithmetic rounding model (quotient/remainder on the integer mantissa).
module tb_fpu_norm_pipe;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic              sign_i = 1'b0;
  logic signed [9:0] exp_i = '0;
  logic [47:0]       mant_i = '0;
  logic [1:0]        rm_i = '0;
  logic              valid_o;
  logic              ready_i = 1'b1;
  logic [31:0]       result_o;
  logic              of_o, uf_o, nx_o;

  int          n_vec = 0;
  int          n_err = 0;
  int          pops = 0;
  logic [34:0] exp_q[$];
  logic        stalled = 1'b0;
  logic [34:0] held = '0;

  always #5 clk = ~clk;

  fpu_norm_pipe dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Valid_SI(valid_i), .Ready_SO(ready_o),
    .Sign_prenorm_DI(sign_i), .Exp_prenorm_DI(exp_i), .Mant_prenorm_DI(mant_i),
    .Rm_SI(rm_i), .Valid_SO(valid_o), .Ready_SI(ready_i), .Result_DO(result_o),
    .OF_SO(of_o), .UF_SO(uf_o), .NX_SO(nx_o)
  );

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Result = m * 2^(e-127-46), rounded to a 24-bit significand by integer division.
  function automatic logic [34:0] model(input logic sg, input int e, input logic [47:0] m,
                                        input logic [1:0] rm);
    longint unsigned mv, q, rem, half;
    int p, ex, sh;
    logic inexact, up;
    mv = 64'(m);
    if (m == 48'd0) return {sg, 31'b0, 3'b000};
    p = 0;
    while ((mv >> (p + 1)) != 0) p++;
    ex = e + p - 46;
    if (p >= 23) begin
      sh   = p - 23;
      q    = mv >> sh;
      rem  = mv - (q << sh);
      half = (sh > 0) ? (64'd1 << (sh - 1)) : 64'd0;
    end else begin
      q    = mv << (23 - p);
      rem  = 0;
      half = 0;
    end
    inexact = (rem != 0);
    case (rm)
      2'd0:    up = (rem > half) || (inexact && rem == half && q[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = inexact && !sg;
      default: up = inexact && sg;
    endcase
    if (ex <= 0) return {sg, 31'b0, 3'b011};
    q = q + 64'(up);
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      ex++;
    end
    if (ex >= 255) begin
      if (rm == 2'd0 || (rm == 2'd2 && !sg) || (rm == 2'd3 && sg))
        return {sg, 8'hFF, 23'h0, 3'b101};
      return {sg, 8'hFE, 23'h7FFFFF, 3'b101};
    end
    return {sg, ex[7:0], q[22:0], 2'b00, inexact};
  endfunction

  // One clock cycle: drive, check handshakes at the falling edge, update the scoreboard.
  task automatic step(input logic v, input logic sg, input int e, input logic [47:0] m,
                      input logic [1:0] rm, input logic rdy);
    logic [34:0] obs;
    valid_i = v; sign_i = sg; exp_i = e[9:0]; mant_i = m; rm_i = rm; ready_i = rdy;
    @(negedge clk);
    obs = {result_o, of_o, uf_o, nx_o};
    chk("ready_o", {34'b0, ready_o}, {34'b0, (exp_q.size() < 2) || rdy});
    if (exp_q.size() == 0) chk("idle_valid", {34'b0, valid_o}, 35'd0);
    if (stalled) begin
      chk("hold_valid", {34'b0, valid_o}, 35'd1);
      chk("hold_data", obs, held);
    end
    if (valid_o && rdy && exp_q.size() != 0) begin
      chk("result", obs, exp_q.pop_front());
      pops++;
    end
    stalled = valid_o && !rdy;
    held = obs;
    if (v && ready_o) exp_q.push_back(model(sg, e, m, rm));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic sg, input int e, input logic [47:0] m,
                          input logic [1:0] rm, input logic [34:0] expv);
    step(1'b1, sg, e, m, rm, 1'b1);
    chk({tag, "_lat1"}, {34'b0, valid_o}, 35'd0);
    step(1'b0, 1'b0, 0, 48'd0, 2'd0, 1'b1);
    chk({tag, "_lat2"}, {34'b0, valid_o}, 35'd1);
    chk(tag, {result_o, of_o, uf_o, nx_o}, expv);
    step(1'b0, 1'b0, 0, 48'd0, 2'd0, 1'b1);
  endtask

  initial begin
    int p0, tgt, e, guard;
    logic [47:0] m;
    logic [63:0] r64;

    #12;
    chk("rst_out", {result_o, of_o, uf_o, nx_o}, 35'd0);
    chk("rst_valid", {34'b0, valid_o}, 35'd0);
    chk("rst_ready", {34'b0, ready_o}, 35'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("one",     1'b0, 157, 48'h000000010000, 2'd0, {32'h3F800000, 3'b000});
    directed("tie_rne", 1'b0, 157, 48'h010000010000, 2'd0, {32'h4B800000, 3'b001});
    directed("tie_rup", 1'b0, 157, 48'h010000010000, 2'd2, {32'h4B800001, 3'b001});
    directed("ovfpos",  1'b1, 157, 48'h800000000000, 2'd0, {32'hCF000000, 3'b000});
    directed("of_rne",  1'b0, 300, 48'h400000000000, 2'd0, {32'h7F800000, 3'b101});
    directed("of_rtz",  1'b0, 300, 48'h400000000000, 2'd1, {32'h7F7FFFFF, 3'b101});
    directed("uf_neg",  1'b0, -5,  48'h400000000000, 2'd0, {32'h00000000, 3'b011});
    directed("uf_zero", 1'b0, 0,   48'h400000000000, 2'd0, {32'h00000000, 3'b011});
    directed("min_nrm", 1'b0, 1,   48'h400000000000, 2'd0, {32'h00800000, 3'b000});
    directed("zero",    1'b1, 100, 48'h000000000000, 2'd0, {32'h80000000, 3'b000});
    directed("rc_of",   1'b0, 255, 48'h3FFFFFFFFFFF, 2'd0, {32'h7F800000, 3'b101});
    directed("rc_rtz",  1'b0, 255, 48'h3FFFFFFFFFFF, 2'd1, {32'h7F7FFFFF, 3'b001});
    directed("of_rdn",  1'b1, 300, 48'h400000000000, 2'd3, {32'hFF800000, 3'b101});
    directed("of_rupn", 1'b1, 300, 48'h400000000000, 2'd2, {32'hFF7FFFFF, 3'b101});

    // Back-pressure: two operands fill the pipe, the third waits until downstream frees up.
    step(1'b1, 1'b0, 140, 48'h123456789ABC, 2'd0, 1'b0);
    step(1'b1, 1'b1, 130, 48'h0000FFFFFFFF, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 120, 48'h00ABCDEF0123, 2'd2, 1'b0);
    chk("stall_ready", {34'b0, ready_o}, 35'd0);
    pops = 0;
    step(1'b1, 1'b0, 120, 48'h00ABCDEF0123, 2'd2, 1'b1);
    step(1'b0, 1'b0, 0, 48'd0, 2'd0, 1'b1);
    step(1'b0, 1'b0, 0, 48'd0, 2'd0, 1'b1);
    chk("drain_rate", 35'(pops), 35'd3);

    // Reset with both stages occupied.
    step(1'b1, 1'b0, 150, 48'h00F00F00F00F, 2'd0, 1'b0);
    step(1'b1, 1'b1, 160, 48'h700000000001, 2'd1, 1'b0);
    valid_i = 1'b0;
    chk("pre_rst_valid", {34'b0, valid_o}, 35'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_valid", {34'b0, valid_o}, 35'd0);
    chk("rst2_ready", {34'b0, ready_o}, 35'd1);
    chk("rst2_out", {result_o, of_o, uf_o, nx_o}, 35'd0);
    exp_q.delete();
    stalled = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 48'd0, 2'd0, 1'b1);

    // Random traffic aimed at the underflow, overflow and mid-range exponent bands.
    for (int n = 0; n < 400; n++) begin
      r64 = {$urandom, $urandom};
      m = (($urandom_range(0, 15) == 0) ? 48'd0 : r64[47:0]) >> $urandom_range(0, 47);
      p0 = 0;
      for (int b = 0; b < 48; b++) if (m[b]) p0 = b;
      case ($urandom_range(0, 3))
        0:       tgt = int'($urandom_range(0, 5)) - 2;
        1:       tgt = int'($urandom_range(252, 256));
        default: tgt = int'($urandom_range(1, 254));
      endcase
      e = tgt + 46 - p0;
      step($urandom_range(0, 3) != 0, 1'($urandom), e, m, 2'($urandom),
           $urandom_range(0, 3) != 0);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      step(1'b0, 1'b0, 0, 48'd0, 2'd0, 1'b1);
      guard++;
    end
    chk("drain_empty", 35'(exp_q.size()), 35'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fpu_norm_pipe.md
FPU_NORM_PIPE -- requirements
Module: fpu_norm_pipe

Interface
REQ-001 SHALL have parameter C_OP, default 32, meaning packed single-precision result width.
REQ-002 SHALL have parameter C_EXP_PRENORM, default 10, meaning signed prenormalised exponent width.
REQ-003 SHALL have parameter C_MANT_PRENORM_W, default 48, meaning prenormalised mantissa width.
REQ-004 SHALL have parameter C_BIAS, default 127, meaning exponent bias.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: Clk_CI  in  1  clock, rising edge.
REQ-006 SHALL have Rst_RBI  in  1  asynchronous active-low reset.
REQ-007 SHALL have Valid_SI  in  1  upstream operand valid.
REQ-008 SHALL have Ready_SO  out  1  block can accept operand this cycle.
REQ-009 SHALL have Sign_prenorm_DI  in  1  operand sign.
REQ-010 SHALL have Exp_prenorm_DI  in  C_EXP_PRENORM  signed biased exponent; mantissa bit 46 carries weight 2^(E-C_BIAS).
REQ-011 SHALL have Mant_prenorm_DI  in  C_MANT_PRENORM_W  unsigned mantissa; bit 47 is the overflow position (weight 2^(E-C_BIAS+1)).
REQ-012 SHALL have Rm_SI  in  2  rounding mode: 0 nearest-even, 1 truncate, 2 +inf, 3 -inf; sampled with the operand.
REQ-013 SHALL have Valid_SO  out  1  result valid.
REQ-014 SHALL have Ready_SI  in  1  downstream accepts result.
REQ-015 SHALL have Result_DO  out  C_OP  packed IEEE-754 single result.
REQ-016 SHALL have OF_SO, UF_SO, NX_SO  out  1 each  overflow, underflow, inexact flags, qualified by Valid_SO.

Function
REQ-017 SHALL be a two-stage pipeline: S1 = leading-one detect and normalising shift; S2 = round, range check, pack.
REQ-018 SHALL accept an operand when Valid_SI & Ready_SO; result is presented 2 cycles later with no stall; throughput 1 per cycle.
REQ-019 SHALL drive Ready_SO = ~S1_valid | ~S2_valid | Ready_SI (combinational from Ready_SI and state only, never from Valid_SI).
REQ-020 SHALL hold Result_DO, flags and Valid_SO stable while Valid_SO & ~Ready_SI; S1 holds when S2 is stalled.
REQ-021 S1: p = index of leading one of mantissa (0..47); exponent = E + (p-46), computed as 11-bit signed; mantissa left-shifted so leading one sits at bit 46.
REQ-022 S1: fraction = shifted bits [45:23], guard G = bit 22, sticky S = OR of bits [21:0].
REQ-023 S2 round increment: RNE: G & (S | frac[0]); truncate: 0; +inf: (G|S) & ~sign; -inf: (G|S) & sign.
REQ-024 S2: fraction carry-out from rounding SHALL zero the fraction and increment the exponent by 1.
REQ-025 Zero mantissa SHALL yield {sign, 31'b0}, all flags 0.
REQ-026 Pre-round exponent <= 0 SHALL yield {sign, 31'b0}, UF=1, NX=1 (no denormal output).
REQ-027 Post-round exponent >= 255 SHALL set OF=1, NX=1; result = ±inf for RNE, for +inf when positive, for -inf when negative; otherwise ±max finite (0x7F7FFFFF magnitude).
REQ-028 NX SHALL be G|S for all in-range results.
REQ-029 Simultaneous accept and S2 drain SHALL both occur in the same cycle with no bubble.

Reset
REQ-030 On Rst_RBI low, all valid bits, Valid_SO, Result_DO and flags SHALL clear to 0 asynchronously; Ready_SO = 1.
REQ-031 Reset asserted mid-operation SHALL discard in-flight operands; no result appears after release.
REQ-032 After reset release, first acceptance occurs on the first rising edge with Valid_SI high.

Verification
REQ-033 E=157, M=0x000000010000, RNE, Ready_SI=1 -> 2 cycles later Result_DO=0x3F800000, flags 0.
REQ-034 E=157, M=0x010000010000 (int 16777217): RNE -> 0x4B800000, NX=1; Rm=2 -> 0x4B800001, NX=1.
REQ-035 Sign=1, E=157, M=0x800000000000 -> 0xCF000000, flags 0.
REQ-036 E=300, M=0x400000000000: RNE -> 0x7F800000, OF=1, NX=1; Rm=1 -> 0x7F7FFFFF, OF=1; E=-5 same M -> 0x00000000, UF=1, NX=1.
REQ-037 Three back-to-back operands with Ready_SI low 3 cycles -> two accepted, Ready_SO low, outputs stable; Ready_SI high -> all three drain in order, one per cycle.
REQ-038 Reset pulse with both stages valid -> Valid_SO=0, Ready_SO=1 immediately; no stale result after release.
